// File: rtl/color_pkg.sv
// Shared types and constants for the Color FSM driver.
//   Color_state : target/decoded colour (Blue=0, Red=1)
//   OUT_*       : FSM output codes observed by the driver
//   IN_*        : FSM input codes driven by the driver
//   drv_state_t : driver FSM states
//   resp_err_t  : response error codes
package color_pkg;

    typedef enum logic {
        Blue = 1'b0,
        Red  = 1'b1
    } Color_state;

    localparam logic [1:0] OUT_BLUE  = 2'h1;
    localparam logic [1:0] OUT_RED   = 2'h2;
    localparam logic [1:0] IN_TOGGLE = 2'h1;
    localparam logic [1:0] IN_HOLD   = 2'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        PULSE = 2'd2,
        RESP  = 2'd3
    } drv_state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TRIES   = 2'd2
    } resp_err_t;

endpackage

// File: rtl/color_out_decoder.sv
// Combinational decode of the Color FSM output code.
// Ports:
//   i_fsm_out : observed FSM output code
//   o_legal   : 1 when the code is OUT_BLUE or OUT_RED
//   o_color   : decoded colour (Blue when the code is illegal)
module color_out_decoder
    import color_pkg::*;
(
    input  logic [1:0] i_fsm_out,
    output logic       o_legal,
    output Color_state o_color
);

    always_comb begin
        o_legal = 1'b0;
        o_color = Blue;
        case (i_fsm_out)
            OUT_BLUE: begin
                o_legal = 1'b1;
                o_color = Blue;
            end
            OUT_RED: begin
                o_legal = 1'b1;
                o_color = Red;
            end
            default: begin
                o_legal = 1'b0;
                o_color = Blue;
            end
        endcase
    end

endmodule

// File: rtl/color_fsm_driver.sv
// Initiator for the 2-bit Color FSM interface: takes a target-colour request,
// pulses the FSM toggle input until the observed colour matches (or tries run
// out / the code is illegal) and returns colour + error on a valid/ready channel.
// Optional feature macro: COLOR_DRV_STATS_EN adds a saturating toggle counter.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_req_valid    : request valid       o_req_ready  : request ready (IDLE only)
//   i_req_color    : target colour
//   o_resp_valid   : response valid      i_resp_ready : response ready
//   o_resp_color   : colour at completion
//   o_resp_err     : 0 OK, 1 illegal out code, 2 tries exhausted
//   i_fsm_out      : observed FSM output code
//   o_fsm_in       : FSM input drive (registered)
//   o_toggle_cnt   : total pulses issued (COLOR_DRV_STATS_EN only)
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CHECK | sample fsm_out, decide done / pulse again
// PULSE | fsm_in is IN_TOGGLE for this single cycle
// RESP  | response presented until accepted
module color_fsm_driver
    import color_pkg::*;
#(
    parameter int MAX_TRIES = 3
`ifdef COLOR_DRV_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_color,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic             o_resp_color,
    output logic [1:0]       o_resp_err,
    input  logic [1:0]       i_fsm_out,
    output logic [1:0]       o_fsm_in
`ifdef COLOR_DRV_STATS_EN
    ,
    output logic [CNT_W-1:0] o_toggle_cnt
`endif
);

    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    drv_state_t         r_state,      w_state_nxt;
    Color_state         r_target,     w_target_nxt;
    logic [TRIES_W-1:0] r_tries,      w_tries_nxt;
    logic [1:0]         r_fsm_in,     w_fsm_in_nxt;
    Color_state         r_resp_color, w_resp_color_nxt;
    resp_err_t          r_resp_err,   w_resp_err_nxt;

    logic               w_legal;
    Color_state         w_color;

    color_out_decoder u_dec (
        .i_fsm_out (i_fsm_out),
        .o_legal   (w_legal),
        .o_color   (w_color)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_target     <= Blue;
            r_tries      <= '0;
            r_fsm_in     <= IN_HOLD;
            r_resp_color <= Blue;
            r_resp_err   <= ERR_OK;
        end else begin
            r_state      <= w_state_nxt;
            r_target     <= w_target_nxt;
            r_tries      <= w_tries_nxt;
            r_fsm_in     <= w_fsm_in_nxt;
            r_resp_color <= w_resp_color_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_target_nxt     = r_target;
        w_tries_nxt      = r_tries;
        w_fsm_in_nxt     = IN_HOLD;     // a toggle is only ever one cycle wide
        w_resp_color_nxt = r_resp_color;
        w_resp_err_nxt   = r_resp_err;
        o_req_ready      = 1'b0;
        o_resp_valid     = 1'b0;

        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_target_nxt = Color_state'(i_req_color);
                    w_tries_nxt  = '0;
                    w_state_nxt  = CHECK;
                end
            end
            CHECK: begin
                w_resp_color_nxt = w_legal ? w_color : Blue;
                if (!w_legal) begin
                    w_resp_err_nxt = ERR_ILLEGAL;
                    w_state_nxt    = RESP;
                end else if (w_color == r_target) begin
                    w_resp_err_nxt = ERR_OK;
                    w_state_nxt    = RESP;
                end else if (r_tries == TRIES_W'(MAX_TRIES)) begin
                    w_resp_err_nxt = ERR_TRIES;
                    w_state_nxt    = RESP;
                end else begin
                    w_fsm_in_nxt = IN_TOGGLE;
                    w_tries_nxt  = r_tries + TRIES_W'(1);
                    w_state_nxt  = PULSE;
                end
            end
            PULSE: begin
                w_state_nxt = CHECK;
            end
            RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_fsm_in     = r_fsm_in;
    assign o_resp_color = r_resp_color;
    assign o_resp_err   = r_resp_err;

`ifdef COLOR_DRV_STATS_EN
    logic             w_pulse_start;
    logic [CNT_W-1:0] r_toggle_cnt;

    assign w_pulse_start = (r_state == CHECK) && (w_state_nxt == PULSE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toggle_cnt <= '0;
        end else if (w_pulse_start && (r_toggle_cnt != '1)) begin
            r_toggle_cnt <= r_toggle_cnt + CNT_W'(1);
        end
    end

    assign o_toggle_cnt = r_toggle_cnt;
`endif

endmodule

// File: tb/tb_color_fsm_driver.sv
// Bench for color_fsm_driver: a behavioural Color FSM model answers the
// driver's toggles; a table of request scenarios is applied and latency,
// colour, error, pulse count and first-pulse cycle are compared.
module tb_color_fsm_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_req_valid = 1'b0;
    logic       o_req_ready;
    logic       i_req_color = 1'b0;
    logic       o_resp_valid;
    logic       i_resp_ready = 1'b0;
    logic       o_resp_color;
    logic [1:0] o_resp_err;
    logic [1:0] i_fsm_out;
    logic [1:0] o_fsm_in;
`ifdef COLOR_DRV_STATS_EN
    logic [15:0] o_toggle_cnt;
`endif

    always #5 clk = ~clk;

    color_fsm_driver #(.MAX_TRIES(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_color  (i_req_color),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_color (o_resp_color),
        .o_resp_err   (o_resp_err),
        .i_fsm_out    (i_fsm_out),
        .o_fsm_in     (o_fsm_in)
`ifdef COLOR_DRV_STATS_EN
        ,
        .o_toggle_cnt (o_toggle_cnt)
`endif
    );

    // Color FSM model: loadable, toggles on fsm_in==2'h1 unless told to ignore it.
    logic m_load = 1'b0;
    logic m_load_val = 1'b0;
    logic m_ignore = 1'b0;
    logic m_illegal = 1'b0;
    logic m_red = 1'b0;
    int   m_pulses = 0;

    always @(posedge clk) begin
        if (m_load) begin
            m_red    <= m_load_val;
            m_pulses <= 0;
        end else begin
            if (o_fsm_in == 2'h1) begin
                m_pulses <= m_pulses + 1;
                if (!m_ignore) m_red <= ~m_red;
            end
        end
    end

    assign i_fsm_out = m_illegal ? 2'h3 : (m_red ? 2'h2 : 2'h1);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        bit    start_red;
        bit    ignore;
        bit    illegal;
        bit    req_color;
        int    exp_lat;
        int    exp_color;
        int    exp_err;
        int    exp_pulses;
        int    exp_first;   // cycle of first fsm_in pulse, 0 when none
    } vec_t;

    vec_t vecs[7];

    task automatic load_model(input bit red, input bit ign, input bit ill);
        @(negedge clk);
        m_load     = 1'b1;
        m_load_val = red;
        m_ignore   = ign;
        m_illegal  = ill;
        @(negedge clk);
        m_load     = 1'b0;
    endtask

    // Issues one request, returns observed latency and first pulse cycle.
    task automatic run_req(input bit color, output int lat, output int first);
        i_req_valid = 1'b1;
        i_req_color = color;
        @(posedge clk);             // accept edge = cycle 0
        #1;
        i_req_valid = 1'b0;
        i_req_color = 1'b0;
        lat   = 1;
        first = 0;
        while (!o_resp_valid && lat < 40) begin
            if (o_fsm_in == 2'h1 && first == 0) first = lat;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        i_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        i_resp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int first;
        int tot_pulses;
        int s_color;
        int s_err;
        bit rr_ok;

        vecs[0] = '{"red_to_red",     1, 0, 0, 1, 2, 1, 0, 0, 0};
        vecs[1] = '{"red_to_blue",    1, 0, 0, 0, 4, 0, 0, 1, 2};
        vecs[2] = '{"stuck_blue",     0, 1, 0, 1, 8, 0, 2, 3, 2};
        vecs[3] = '{"illegal_code",   1, 0, 1, 1, 2, 0, 1, 0, 0};
        vecs[4] = '{"blue_to_blue",   0, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[5] = '{"blue_to_red",    0, 0, 0, 1, 4, 1, 0, 1, 2};
        vecs[6] = '{"stuck_red",      1, 1, 0, 0, 8, 1, 2, 3, 2};

        // Reset state
        #12;
        check("rst_req_ready",  int'(o_req_ready),  1);
        check("rst_resp_valid", int'(o_resp_valid), 0);
        check("rst_resp_color", int'(o_resp_color), 0);
        check("rst_resp_err",   int'(o_resp_err),   0);
        check("rst_fsm_in",     int'(o_fsm_in),     0);
`ifdef COLOR_DRV_STATS_EN
        check("rst_toggle_cnt", int'(o_toggle_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        tot_pulses = 0;
        foreach (vecs[i]) begin
            load_model(vecs[i].start_red, vecs[i].ignore, vecs[i].illegal);
            check({vecs[i].name, "_idle_ready"}, int'(o_req_ready), 1);
            run_req(vecs[i].req_color, lat, first);
            check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
            check({vecs[i].name, "_color"}, int'(o_resp_color), vecs[i].exp_color);
            check({vecs[i].name, "_err"}, int'(o_resp_err), vecs[i].exp_err);
            check({vecs[i].name, "_pulses"}, m_pulses, vecs[i].exp_pulses);
            check({vecs[i].name, "_first_pulse"}, first, vecs[i].exp_first);
            tot_pulses += vecs[i].exp_pulses;
            handshake();
        end
`ifdef COLOR_DRV_STATS_EN
        check("toggle_cnt_total", int'(o_toggle_cnt), tot_pulses);
`endif

        // Backpressure: response held, a second request waits with req_valid high.
        load_model(1'b1, 1'b0, 1'b0);
        i_req_valid = 1'b1;
        i_req_color = 1'b0;
        @(posedge clk);
        #1;
        rr_ok = 1'b1;
        lat = 1;
        while (!o_resp_valid && lat < 40) begin
            if (o_req_ready) rr_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", lat, 4);
        i_req_color = 1'b1;
        s_color = int'(o_resp_color);
        s_err   = int'(o_resp_err);
        check("bp_color", s_color, 0);
        check("bp_err", s_err, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (o_req_ready || !o_resp_valid ||
                int'(o_resp_color) != s_color || int'(o_resp_err) != s_err) rr_ok = 1'b0;
        end
        check("bp_stall_stable", int'(rr_ok), 1);
        i_resp_ready = 1'b1;
        @(posedge clk);             // response handshake edge
        #1;
        i_resp_ready = 1'b0;
        check("bp_after_hs_ready", int'(o_req_ready), 1);
        check("bp_after_hs_valid", int'(o_resp_valid), 0);
        @(posedge clk);             // second request accepted here
        #1;
        i_req_valid = 1'b0;
        i_req_color = 1'b0;
        check("bp_second_accepted", int'(o_req_ready), 0);
        lat = 1;
        while (!o_resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_second_latency", lat, 4);
        check("bp_second_color", int'(o_resp_color), 1);
        handshake();

        // Reset asserted during PULSE aborts silently.
        load_model(1'b1, 1'b0, 1'b0);
        i_req_valid = 1'b1;
        i_req_color = 1'b0;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pulse_before_rst", int'(o_fsm_in), 1);
        rst = 1'b1;
        #1;
        check("rst_pulse_fsm_in", int'(o_fsm_in), 0);
        check("rst_pulse_resp_valid", int'(o_resp_valid), 0);
        check("rst_pulse_req_ready", int'(o_req_ready), 1);
`ifdef COLOR_DRV_STATS_EN
        check("rst_pulse_toggle_cnt", int'(o_toggle_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (o_resp_valid) rr_ok = 1'b0;
        end
        check("rst_no_response", int'(o_resp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
